lzma2_job_ctrl: RTL

//  Sequences one LZMA2 compression job of up to INPUT_SIZE bytes. Gates the 256-bit chunk

---
 rtl/lzma2_pkg.sv | 26 ++
 rtl/lzma2_job_watchdog.sv | 38 +++
 rtl/lzma2_job_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lzma2_pkg.sv
// lzma2_pkg: shared job-controller types, status layout and error codes
package lzma2_pkg;
  localparam int CHUNK_BYTES = 32;
  localparam logic [3:0] ERR_NONE     = 4'h0;
  localparam logic [3:0] ERR_OVERFLOW = 4'h3;
  localparam logic [3:0] ERR_TIMEOUT  = 4'h4;
  localparam logic [3:0] ERR_STALL    = 4'h6;
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_LOAD  = 4'd2,
    ST_DRAIN = 4'd3,
    ST_DONE  = 4'd4,
    ST_ERROR = 4'd5
  } job_state_t;
  typedef struct packed {
    logic [15:0] rsvd;
    logic [3:0]  error_code;
    logic [3:0]  warning_flags;
    logic [3:0]  state;
    logic        in_load;
    logic        error;
    logic        done_sticky;
    logic        busy;
  } status_reg_t;
endpackage

// File: rtl/lzma2_job_watchdog.sv
// lzma2_job_watchdog: job cycle, stall-run and cumulative stall counters
// Hits fire on the edge that makes a counter reach its limit, so the counters end exactly at the limit.
module lzma2_job_watchdog #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int STALL_LIMIT    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        count_en,
  input  logic        stall,
  output logic [31:0] cycles,
  output logic [31:0] stall_cycles,
  output logic        timeout_hit,
  output logic        stall_hit
);
  logic [31:0] cycles_q, cycles_d, stall_run_q, stall_run_d, stall_cycles_q, stall_cycles_d;
  always_comb begin
    cycles_d       = clear ? '0 : (count_en && cycles_q != '1) ? cycles_q + 32'd1 : cycles_q;
    stall_run_d    = (clear || !stall) ? '0 : stall_run_q + 32'd1;
    stall_cycles_d = clear ? '0 : (stall && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q       <= '0;
      stall_run_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      cycles_q       <= cycles_d;
      stall_run_q    <= stall_run_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign cycles       = cycles_q;
  assign stall_cycles = stall_cycles_q;
  assign timeout_hit  = count_en && cycles_q == 32'(TIMEOUT_CYCLES - 1);
  assign stall_hit    = stall && stall_run_q == 32'(STALL_LIMIT - 1);
endmodule

// File: rtl/lzma2_job_ctrl.sv
// lzma2_job_ctrl: sequences one LZMA2 compression job and gates the host->engine chunk handshake
module lzma2_job_ctrl
  import lzma2_pkg::*;
#(
  parameter int INPUT_SIZE     = 32768,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int STALL_LIMIT    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [5:0]  in_last_bytes,
  output logic        in_ready,
  output logic        eng_start,
  output logic        eng_abort,
  output logic        eng_valid,
  input  logic        eng_ready,
  input  logic        eng_done,
  input  logic        eng_err,
  input  logic [3:0]  eng_err_code,
  output logic        busy,
  output logic        done,
  output logic [31:0] status,
  output logic [31:0] total_bytes,
  output logic [31:0] cycles,
  output logic [31:0] stall_cycles
);
  job_state_t  state_q, state_d;
  logic [31:0] total_q, total_d;
  logic [3:0]  err_q, err_d, warn_q, warn_d;
  logic        sticky_q, sticky_d, eng_abort_q, eng_abort_d;
  logic        start_ok, ovf, xfer, stall, timeout_hit, stall_hit;
  status_reg_t st;
  assign busy     = state_q == ST_START || state_q == ST_LOAD || state_q == ST_DRAIN;
  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_ERROR);
  // A full job blocks any further chunk; an oversized last chunk is rejected rather than forwarded.
  assign ovf      = in_valid && (total_q == 32'(INPUT_SIZE) ||
                    (in_last && total_q + 32'(in_last_bytes) > 32'(INPUT_SIZE)));
  assign xfer     = state_q == ST_LOAD && in_valid && eng_ready && !ovf;
  assign stall    = state_q == ST_LOAD && in_valid && !eng_ready;
  assign in_ready  = state_q == ST_LOAD && !ovf ? eng_ready : 1'b0;
  assign eng_valid = state_q == ST_LOAD && !ovf ? in_valid : 1'b0;
  always_comb begin
    state_d  = state_q;
    total_d  = xfer ? total_q + (in_last ? 32'(in_last_bytes) : 32'(CHUNK_BYTES)) : total_q;
    err_d    = err_q;
    warn_d   = warn_q | {3'b000, start && busy};
    sticky_d = sticky_q;
    if (start_ok) begin
      state_d  = ST_START;
      total_d  = '0;
      err_d    = ERR_NONE;
      warn_d   = '0;
      sticky_d = 1'b0;
    end else if (abort && busy) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_START: begin
          state_d = timeout_hit ? ST_ERROR : ST_LOAD;
          err_d   = timeout_hit ? ERR_TIMEOUT : err_q;
        end
        ST_LOAD: begin
          if (xfer && in_last) state_d = ST_DRAIN;
          else if (ovf || stall_hit || timeout_hit) begin
            state_d = ST_ERROR;
            err_d   = ovf ? ERR_OVERFLOW : stall_hit ? ERR_STALL : ERR_TIMEOUT;
          end
        end
        ST_DRAIN: begin
          if (eng_done) begin
            state_d  = ST_DONE;
            sticky_d = 1'b1;
          end else if (eng_err || timeout_hit) begin
            state_d = ST_ERROR;
            err_d   = eng_err ? eng_err_code : ERR_TIMEOUT;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end
  assign eng_abort_d = busy && (abort || state_d == ST_ERROR);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      total_q     <= '0;
      err_q       <= '0;
      warn_q      <= '0;
      sticky_q    <= 1'b0;
      eng_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      err_q       <= err_d;
      warn_q      <= warn_d;
      sticky_q    <= sticky_d;
      eng_abort_q <= eng_abort_d;
    end
  end
  lzma2_job_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .STALL_LIMIT   (STALL_LIMIT)
  ) u_wd (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_ok),
    .count_en    (busy),
    .stall       (stall),
    .cycles      (cycles),
    .stall_cycles(stall_cycles),
    .timeout_hit (timeout_hit),
    .stall_hit   (stall_hit)
  );
  assign st          = {16'h0, err_q, warn_q, state_q, state_q == ST_LOAD, state_q == ST_ERROR, sticky_q, busy};
  assign status      = st;
  assign eng_start   = state_q == ST_START;
  assign eng_abort   = eng_abort_q;
  assign done        = state_q == ST_DONE;
  assign total_bytes = total_q;
endmodule
